// File: rtl/toysram_2r1w_array.sv
// Parametrised 2-read/1-write storage array with registered reads, write-through bypass
// and a post-reset clear sequencer. Optional row parity: define TOYSRAM_2R1W_PARITY_EN.

module toysram_2r1w_rdport #(
  parameter int BITS  = 12,
  parameter int ROW_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             enb,
  input  logic             in_range,
  input  logic             hit,
  input  logic [ROW_W-1:0] row,
  input  logic [BITS-1:0]  wr_dat,
  output logic [BITS-1:0]  dat,
`ifdef TOYSRAM_2R1W_PARITY_EN
  output logic             perr,
`endif
  output logic             vld
);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= 1'b0;
      dat <= '0;
`ifdef TOYSRAM_2R1W_PARITY_EN
      perr <= 1'b0;
`endif
    end else if (ready && enb) begin
      vld <= 1'b1;
      // Out-of-range rows read as zero; a same-cycle write wins over the stored row.
      if (!in_range)  dat <= '0;
      else if (hit)   dat <= wr_dat;
      else            dat <= row[BITS-1:0];
`ifdef TOYSRAM_2R1W_PARITY_EN
      perr <= in_range && !hit && (^row);
`endif
    end else begin
      vld <= 1'b0;
    end
  end

endmodule

module toysram_2r1w_array #(
  parameter int WORDS  = 16,
  parameter int BITS   = 12,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              rd0_enb,
  input  logic [ADDR_W-1:0] rd0_adr,
  output logic [BITS-1:0]   rd0_dat,
  output logic              rd0_vld,
  input  logic              rd1_enb,
  input  logic [ADDR_W-1:0] rd1_adr,
  output logic [BITS-1:0]   rd1_dat,
  output logic              rd1_vld,
  input  logic              wr_enb,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [BITS-1:0]   wr_dat,
`ifdef TOYSRAM_2R1W_PARITY_EN
  input  logic              inj_perr,
  output logic              rd0_perr,
  output logic              rd1_perr,
`endif
  output logic              wr_err
);

  localparam int NUM_RD = 2;
`ifdef TOYSRAM_2R1W_PARITY_EN
  localparam int ROW_W = BITS + 1;
`else
  localparam int ROW_W = BITS;
`endif
  localparam logic [ADDR_W:0]   WORDS_LIM = (ADDR_W+1)'(WORDS);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(WORDS - 1);

  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] init_cnt;
  logic [ROW_W-1:0]  mem [WORDS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [ROW_W-1:0]  mem_wd;
  logic [ROW_W-1:0]  wr_row;
  logic              wr_in_range, wr_fire;

  assign wr_in_range = {1'b0, wr_adr} < WORDS_LIM;
  assign wr_fire     = ready && wr_enb && wr_in_range;
`ifdef TOYSRAM_2R1W_PARITY_EN
  assign wr_row = {(^wr_dat) ^ inj_perr, wr_dat};
`else
  assign wr_row = wr_dat;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_cnt == LAST_ROW) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // The clear sequencer owns the write port until every row has been zeroed.
  always_comb begin
    ready  = 1'b0;
    mem_we = 1'b0;
    mem_wa = wr_adr;
    mem_wd = wr_row;
    case (state)
      INIT: begin
        mem_we = 1'b1;
        mem_wa = init_cnt;
        mem_wd = '0;
      end
      default: begin
        ready  = 1'b1;
        mem_we = wr_fire;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)              init_cnt <= '0;
    else if (state == INIT) init_cnt <= init_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) wr_err <= 1'b0;
    else       wr_err <= wr_enb && (!ready || !wr_in_range);
  end

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_adr;
  logic [NUM_RD-1:0]             rd_enb, rd_vld;
  logic [NUM_RD-1:0][BITS-1:0]   rd_dat;
`ifdef TOYSRAM_2R1W_PARITY_EN
  logic [NUM_RD-1:0]             rd_perr;
  assign rd0_perr = rd_perr[0];
  assign rd1_perr = rd_perr[1];
`endif

  assign rd_adr  = {rd1_adr, rd0_adr};
  assign rd_enb  = {rd1_enb, rd0_enb};
  assign rd0_dat = rd_dat[0];
  assign rd1_dat = rd_dat[1];
  assign rd0_vld = rd_vld[0];
  assign rd1_vld = rd_vld[1];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    toysram_2r1w_rdport #(.BITS(BITS), .ROW_W(ROW_W)) u_rd (
      .clk      (clk),
      .reset    (reset),
      .ready    (ready),
      .enb      (rd_enb[i]),
      .in_range ({1'b0, rd_adr[i]} < WORDS_LIM),
      .hit      (wr_fire && (wr_adr == rd_adr[i])),
      .row      (mem[rd_adr[i]]),
      .wr_dat   (wr_dat),
      .dat      (rd_dat[i]),
`ifdef TOYSRAM_2R1W_PARITY_EN
      .perr     (rd_perr[i]),
`endif
      .vld      (rd_vld[i])
    );
  end

endmodule

// File: tb/tb_toysram_2r1w_array.sv
// Directed bench: u is the default 16x12 array, v a 12-row array sharing the same stimulus.

module tb_toysram_2r1w_array;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd0_enb = 1'b0, rd1_enb = 1'b0, wr_enb = 1'b0;
  logic [3:0]  rd0_adr = '0, rd1_adr = '0, wr_adr = '0;
  logic [11:0] wr_dat = '0;
  logic        u_ready, u_rd0_vld, u_rd1_vld, u_wr_err;
  logic [11:0] u_rd0_dat, u_rd1_dat;
  logic        v_ready, v_rd0_vld, v_rd1_vld, v_wr_err;
  logic [11:0] v_rd0_dat, v_rd1_dat;
`ifdef TOYSRAM_2R1W_PARITY_EN
  logic        inj_perr = 1'b0;
  logic        u_rd0_perr, u_rd1_perr, v_rd0_perr, v_rd1_perr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toysram_2r1w_array u_dut (
    .clk(clk), .reset(reset), .ready(u_ready),
    .rd0_enb(rd0_enb), .rd0_adr(rd0_adr), .rd0_dat(u_rd0_dat), .rd0_vld(u_rd0_vld),
    .rd1_enb(rd1_enb), .rd1_adr(rd1_adr), .rd1_dat(u_rd1_dat), .rd1_vld(u_rd1_vld),
    .wr_enb(wr_enb), .wr_adr(wr_adr), .wr_dat(wr_dat),
`ifdef TOYSRAM_2R1W_PARITY_EN
    .inj_perr(inj_perr), .rd0_perr(u_rd0_perr), .rd1_perr(u_rd1_perr),
`endif
    .wr_err(u_wr_err)
  );

  toysram_2r1w_array #(.WORDS(12), .BITS(12), .ADDR_W(4)) v_dut (
    .clk(clk), .reset(reset), .ready(v_ready),
    .rd0_enb(rd0_enb), .rd0_adr(rd0_adr), .rd0_dat(v_rd0_dat), .rd0_vld(v_rd0_vld),
    .rd1_enb(rd1_enb), .rd1_adr(rd1_adr), .rd1_dat(v_rd1_dat), .rd1_vld(v_rd1_vld),
    .wr_enb(wr_enb), .wr_adr(wr_adr), .wr_dat(wr_dat),
`ifdef TOYSRAM_2R1W_PARITY_EN
    .inj_perr(inj_perr), .rd0_perr(v_rd0_perr), .rd1_perr(v_rd1_perr),
`endif
    .wr_err(v_wr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    rd0_enb = 1'b1; rd0_adr = a0;
    rd1_enb = 1'b1; rd1_adr = a1;
    tick();
    rd0_enb = 1'b0; rd1_enb = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    wr_enb = 1'b1; wr_adr = a; wr_dat = d;
    tick();
    wr_enb = 1'b0;
  endtask

  // Releases reset, optionally writes row 2 and reads during INIT, returns ready latencies.
  task automatic release_and_wait(input bit poke, output int nu, output int nv);
    int n = 0;
    nv = 0;
    reset = 1'b0;
    if (poke) begin
      wr_enb = 1'b1; wr_adr = 4'd2; wr_dat = 12'h5A5;
      rd0_enb = 1'b1; rd0_adr = 4'd2;
    end
    do begin
      tick();
      n++;
      if (poke && n == 1) begin
        chk("init_wr_err", {31'b0, u_wr_err}, 32'd1);
        chk("init_rd_vld", {31'b0, u_rd0_vld}, 32'd0);
        wr_enb = 1'b0; rd0_enb = 1'b0;
      end
      if (v_ready && nv == 0) nv = n;
    end while (!u_ready && n < 40);
    nu = n;
  endtask

  initial begin
    int nu, nv;
    tick(); tick();
    chk("rst_ready", {31'b0, u_ready}, 32'd0);
    chk("rst_vld",   {30'b0, u_rd1_vld, u_rd0_vld}, 32'd0);
    chk("rst_dat",   {8'b0, u_rd1_dat, u_rd0_dat}, 32'd0);
    chk("rst_wr_err", {31'b0, u_wr_err}, 32'd0);

    release_and_wait(1'b0, nu, nv);
    chk("ready_lat16", nu, 32'd16);
    chk("ready_lat12", nv, 32'd12);

    // Every row of the 16-row array clears to zero, checked on both ports.
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 4'(15 - a));
      chk($sformatf("clr_r%0d", a), {6'b0, u_rd1_vld, u_rd0_vld, u_rd1_dat, u_rd0_dat}, 32'h3000000);
    end

    wr(4'd5, 12'hABC);
    rd(4'd5, 4'd5);
    chk("wr5_p0", {19'b0, u_rd0_vld, u_rd0_dat}, 32'h1ABC);
    chk("wr5_p1", {19'b0, u_rd1_vld, u_rd1_dat}, 32'h1ABC);

    // Port 0 bypasses the concurrent write to row 3; port 1 reads stored row 4.
    wr(4'd4, 12'h456);
    wr_enb = 1'b1; wr_adr = 4'd3; wr_dat = 12'h123;
    rd(4'd3, 4'd4);
    wr_enb = 1'b0;
    chk("byp_p0", {20'b0, u_rd0_dat}, 32'h123);
    chk("byp_p1", {20'b0, u_rd1_dat}, 32'h456);
    rd(4'd4, 4'd3);
    chk("row3_stored", {20'b0, u_rd1_dat}, 32'h123);

    tick();
    chk("idle_vld",  {31'b0, u_rd0_vld}, 32'd0);
    chk("idle_hold", {20'b0, u_rd0_dat}, 32'h456);

    // Address 13 is past the end of the 12-row array.
    wr(4'd13, 12'h777);
    chk("oob_wr_err_v", {31'b0, v_wr_err}, 32'd1);
    chk("oob_wr_err_u", {31'b0, u_wr_err}, 32'd0);
    tick();
    chk("oob_err_pulse", {31'b0, v_wr_err}, 32'd0);
    rd(4'd13, 4'd1);
    chk("oob_rd_v", {19'b0, v_rd0_vld, v_rd0_dat}, 32'h1000);
    chk("oob_rd_u", {20'b0, u_rd0_dat}, 32'h777);
    chk("oob_row1_v", {20'b0, v_rd1_dat}, 32'h0);
    rd(4'd11, 4'd11);
    chk("last_row_v", {19'b0, v_rd1_vld, v_rd1_dat}, 32'h1000);

    // Reset mid-INIT restarts the full clear sequence.
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_init_rdy", {31'b0, u_ready}, 32'd0);
    reset = 1'b1; tick();
    release_and_wait(1'b1, nu, nv);
    chk("reinit_lat16", nu, 32'd16);
    chk("reinit_lat12", nv, 32'd12);
    rd(4'd2, 4'd5);
    chk("init_wr_dropped", {20'b0, u_rd0_dat}, 32'h0);
    chk("row5_recleared",  {20'b0, u_rd1_dat}, 32'h0);

`ifdef TOYSRAM_2R1W_PARITY_EN
    inj_perr = 1'b1; wr(4'd6, 12'h00F); inj_perr = 1'b0;
    rd(4'd6, 4'd7);
    chk("perr_inj", {19'b0, u_rd0_perr, u_rd0_dat}, 32'h100F);
    chk("perr_clean_row", {31'b0, u_rd1_perr}, 32'd0);
    wr(4'd6, 12'h00F);
    rd(4'd6, 4'd6);
    chk("perr_fixed", {19'b0, u_rd0_perr, u_rd0_dat}, 32'h000F);
    inj_perr = 1'b1; wr_enb = 1'b1; wr_adr = 4'd8; wr_dat = 12'h001;
    rd(4'd8, 4'd9);
    wr_enb = 1'b0; inj_perr = 1'b0;
    chk("perr_bypass", {31'b0, u_rd0_perr}, 32'd0);
    rd(4'd8, 4'd8);
    chk("perr_after_byp", {30'b0, u_rd1_perr, u_rd0_perr}, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toysram_2r1w_array.md
Name: toysram_2r1w_array

Overview:
- Parametrised, synthesizable 2-read/1-write storage array; next generation of the fixed 16x12 10T subarray macro.
- Generalises depth and width, adds registered read ports, a write-to-read bypass, and a post-reset clear sequencer, so that every word holds a known value after reset.
- Sits between the toysram port-control logic and the test/bringup wrapper.
- Serves as a behavioural drop-in for array-only macros where no hard cell exists.

Parameters:
- WORDS, 16, number of rows (wordlines). Must be ≥2.
- BITS, 12, data width per row.
- ADDR_W, 4, address width. Must satisfy 2^ADDR_W ≥ WORDS.

Ports:
- clk  in  1  array clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  array initialised and accepting requests.
- rd0_enb  in  1  read port 0 request.
- rd0_adr  in  ADDR_W  read port 0 row address.
- rd0_dat  out  BITS  read port 0 data.
- rd0_vld  out  1  rd0_dat valid this cycle.
- rd1_enb  in  1  read port 1 request.
- rd1_adr  in  ADDR_W  read port 1 row address.
- rd1_dat  out  BITS  read port 1 data.
- rd1_vld  out  1  rd1_dat valid this cycle.
- wr_enb  in  1  write request.
- wr_adr  in  ADDR_W  write row address.
- wr_dat  in  BITS  write data.
- wr_err  out  1  one-cycle pulse: write rejected (out-of-range address or not ready).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: ready=0, rd0_vld=rd1_vld=0, rd0_dat=rd1_dat=0, wr_err=0, FSM=INIT, init counter=0.
- FSM:
  - INIT: writes 0 to row init_cnt each cycle and increments init_cnt. When init_cnt==WORDS-1 the row is written and the FSM moves to RUN. INIT lasts exactly WORDS cycles after reset deasserts.
  - RUN: ready=1. Services requests. Stays in RUN until reset.
- Reset asserted in any state, including mid-INIT: returns to INIT with init_cnt=0 on the next edge. The clear sequence restarts in full.
- Requests while ready=0:
  - Reads are ignored; vld stays 0.
  - A write asserts wr_err the next cycle and does not modify the array.
- Write: in RUN with wr_enb=1 and wr_adr<WORDS, row wr_adr takes wr_dat at that edge. If wr_adr≥WORDS, no update and wr_err=1 the next cycle.
- Read latency is 1 cycle. rdN_enb=1 in cycle T gives rdN_dat and rdN_vld=1 in cycle T+1.
- Read with rdN_enb=0: rdN_vld=0 next cycle and rdN_dat holds its previous value.
- Read with rdN_adr≥WORDS: rdN_vld=1 and rdN_dat=0.
- Read/write collision: same address in the same cycle T returns wr_dat in T+1 (write-through bypass). This applies independently to each read port.
- Both read ports on the same address return identical data.
- No arithmetic wrap: init_cnt width is ADDR_W. The terminal compare is against WORDS-1, not 2^ADDR_W-1.

Optional Feature:
- Macro: TOYSRAM_2R1W_PARITY_EN.
- Defined:
  - Each row stores BITS+1 bits; the extra bit is even parity of the data, computed on write. INIT writes parity 0.
  - Extra outputs rd0_perr and rd1_perr, each 1 bit, are valid alongside rdN_vld. Each is 1 when the stored parity mismatches the stored data.
  - A bypassed read always has perr=0.
  - Verification-only hook input inj_perr (1 bit) flips the stored parity bit on the current write.
- Undefined: no parity storage, no perr/inj_perr ports, array width exactly BITS.

Test Plan:
- Reset release, WORDS=16: ready rises exactly 16 cycles after reset deasserts. Afterwards, reading rows 0..15 on both ports returns 0 with vld=1.
- Write row 5=0xABC, then next cycle rd0_adr=5 and rd1_adr=5 -> both ports return 0xABC one cycle later.
- Same cycle: wr_adr=3, wr_dat=0x123, rd0_adr=3, rd1_adr=4 (row 4 holding 0x456) -> rd0_dat=0x123 and rd1_dat=0x456 in T+1.
- WORDS=12, ADDR_W=4: write to address 13 -> wr_err pulses one cycle and row contents are unchanged. Read address 13 -> vld=1, dat=0.
- Reset asserted at init cycle 7, then released -> ready rises 16 cycles after release. Write during INIT -> wr_err=1 and the row reads 0 afterwards.
- With TOYSRAM_2R1W_PARITY_EN: write 0x00F with inj_perr=1, then read -> rd0_perr=1. Rewrite with inj_perr=0 -> rd0_perr=0.
